// File: rtl/dut_seven_segment_1.sv
// Single-digit 0..MAX_DIGIT counter with a prescaler and a registered
// common-cathode 7-segment decoder. Optional macro SEG_DP_BLINK_EN drives dp from digit[0].
module dut_seven_segment_1 #(
    parameter int TICK_DIV  = 1,
    parameter int MAX_DIGIT = 9
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] seg
);

    if (TICK_DIV < 1 || TICK_DIV > 65535 || MAX_DIGIT < 1 || MAX_DIGIT > 9) begin : g_param_check
        $error("dut_seven_segment_1: TICK_DIV or MAX_DIGIT out of range");
    end

    localparam logic [15:0] LP_DIV_LAST = 16'(TICK_DIV - 1);
    localparam logic [3:0]  LP_MAX_DIG  = 4'(MAX_DIGIT);

    logic [15:0] r_div_cnt;
    logic [3:0]  r_digit;
    logic [7:0]  r_seg;

    logic        w_step;
    logic [15:0] w_div_nxt;
    logic [3:0]  w_digit_nxt;
    logic        w_dp;
    logic [7:0]  w_seg_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h40;
        endcase
        return code;
    endfunction

    // Next prescaler/digit state; seg is decoded from the next digit so it lands on the same edge.
    always_comb begin
        w_step      = 1'b0;
        w_div_nxt   = r_div_cnt;
        w_digit_nxt = r_digit;
        w_dp        = 1'b0;
        if (r_div_cnt == LP_DIV_LAST) begin
            w_step    = 1'b1;
            w_div_nxt = 16'd0;
        end else begin
            w_step    = 1'b0;
            w_div_nxt = r_div_cnt + 16'd1;
        end
        if (w_step) begin
            if (r_digit == LP_MAX_DIG) begin
                w_digit_nxt = 4'd0;
            end else begin
                w_digit_nxt = r_digit + 4'd1;
            end
        end else begin
            w_digit_nxt = r_digit;
        end
`ifdef SEG_DP_BLINK_EN
        w_dp = w_digit_nxt[0];
`else
        w_dp = 1'b0;
`endif
        w_seg_nxt = {w_dp, seg_decode(w_digit_nxt)};
    end

    // State and output registers; reset wins over a coincident step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= 16'd0;
            r_digit   <= 4'd0;
            r_seg     <= 8'h3F;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_digit   <= w_digit_nxt;
            r_seg     <= w_seg_nxt;
        end
    end

    assign seg = r_seg;

endmodule

// File: tb/tb_dut_seven_segment_1.sv
// Directed bench for dut_seven_segment_1: default instance plus a TICK_DIV=4/MAX_DIGIT=3 instance.
module tb_dut_seven_segment_1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst4;
    logic [7:0] seg;
    logic [7:0] seg4;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int run_dig  [20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0,
                          1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    int div4_dig [20] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2,
                          2, 3, 3, 3, 3, 0, 0, 0, 0, 1};
    int restart4 [4]  = '{0, 0, 0, 1};

    always #5 clk = ~clk;

    dut_seven_segment_1 u_dut (
        .clk(clk),
        .rst(rst),
        .seg(seg)
    );

    dut_seven_segment_1 #(.TICK_DIV(4), .MAX_DIGIT(3)) u_dut4 (
        .clk(clk),
        .rst(rst4),
        .seg(seg4)
    );

    function automatic logic [7:0] exp_seg(input int d);
        logic dp;
`ifdef SEG_DP_BLINK_EN
        dp = d[0];
`else
        dp = 1'b0;
`endif
        return {dp, seg_tbl[d]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        rst4 = 1'b1;

        repeat (10) begin
            tick();
            chk("rst_hold", seg, 8'h3F);
            chk("rst4_hold", seg4, 8'h3F);
        end

        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("run1", seg, exp_seg(run_dig[i]));
        end

        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("pre_rst", seg, exp_seg(i));
        end

        rst = 1'b1;
        tick();
        chk("rst_mid", seg, 8'h3F);
        repeat (20) begin
            tick();
            chk("rst_hold2", seg, 8'h3F);
        end

        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("run2", seg, exp_seg(run_dig[i]));
        end

        rst  = 1'b1;
        rst4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("div4", seg4, exp_seg(div4_dig[i]));
            chk("rst_hold3", seg, 8'h3F);
        end

        repeat (2) begin
            tick();
            chk("div4_pre", seg4, exp_seg(1));
        end
        rst4 = 1'b1;
        tick();
        chk("div4_rst", seg4, 8'h3F);
        rst4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("div4_restart", seg4, exp_seg(restart4[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
